// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a start/busy/done handshake.
// Defining MDU_FAST_MUL_EN gives multiplies a single-cycle path; divides stay iterative.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [4:0]      aluOperation_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    // RV32M operation codes, matching the decoder's definitions.vh encoding
    localparam logic [4:0] ALUOP_MUL    = 5'h10;
    localparam logic [4:0] ALUOP_MULH   = 5'h11;
    localparam logic [4:0] ALUOP_MULHSU = 5'h12;
    localparam logic [4:0] ALUOP_MULHU  = 5'h13;
    localparam logic [4:0] ALUOP_DIV    = 5'h14;
    localparam logic [4:0] ALUOP_DIVU   = 5'h15;
    localparam logic [4:0] ALUOP_REM    = 5'h16;
    localparam logic [4:0] ALUOP_REMU   = 5'h17;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [63:0]     acc_q, acc_d;
    logic [31:0]     opb_q, opb_d;
    logic [4:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] result_q, result_d;

    function automatic logic is_mul_op(input logic [4:0] op);
        return op inside {ALUOP_MUL, ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU};
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return op inside {ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU};
    endfunction

    // acc holds the product for multiplies and {remainder, quotient} for divides
    function automatic logic [31:0] fix_word(input logic [4:0] op, input logic neg,
                                             input logic [63:0] acc);
        logic [63:0] p;
        logic [31:0] w;
        p = neg ? (~acc + 64'd1) : acc;
        w = neg ? (~acc[31:0] + 32'd1) : acc[31:0];
        case (op)
            ALUOP_MUL:                          return p[31:0];
            ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU: return p[63:32];
            ALUOP_DIV, ALUOP_DIVU:              return w;
            default:                            return neg ? (~acc[63:32] + 32'd1) : acc[63:32];
        endcase
    endfunction

    logic        is_mul, is_div, a_signed, b_signed, sa, sb, accept;
    logic        div_zero, div_ovf, short_path;
    logic [31:0] mag_a, mag_b, special_res;
    logic [32:0] div_top;
    logic        div_ge;
    logic [32:0] mul_sum;

    always_comb begin
        is_mul   = is_mul_op(aluOperation_i);
        is_div   = is_div_op(aluOperation_i);
        a_signed = aluOperation_i inside {ALUOP_MULH, ALUOP_MULHSU, ALUOP_DIV, ALUOP_REM};
        b_signed = aluOperation_i inside {ALUOP_MULH, ALUOP_DIV, ALUOP_REM};
        sa       = a_signed & rs1_data_i[31];
        sb       = b_signed & rs2_data_i[31];
        mag_a    = sa ? (~rs1_data_i + 32'd1) : rs1_data_i;
        mag_b    = sb ? (~rs2_data_i + 32'd1) : rs2_data_i;
        accept   = (state_q == S_IDLE) & start_i & ~kill_i & (is_mul | is_div);
        div_zero = is_div & (rs2_data_i == 32'd0);
        div_ovf  = (aluOperation_i inside {ALUOP_DIV, ALUOP_REM}) &
                   (rs1_data_i == 32'h8000_0000) & (rs2_data_i == 32'hFFFF_FFFF);
        if (div_zero)
            special_res = (aluOperation_i inside {ALUOP_DIV, ALUOP_DIVU}) ? 32'hFFFF_FFFF : rs1_data_i;
        else
            special_res = (aluOperation_i == ALUOP_DIV) ? 32'h8000_0000 : 32'd0;
`ifdef MDU_FAST_MUL_EN
        short_path = div_zero | div_ovf | is_mul;
`else
        short_path = div_zero | div_ovf;
`endif
        div_top = acc_q[63:31];
        div_ge  = div_top >= {1'b0, opb_q};
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = short_path ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == 5'd31) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (kill_i) state_d = S_IDLE;
    end

    always_comb begin
        busy_o   = (state_q != S_IDLE);
        done_o   = (state_q == S_DONE);
        result_o = result_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (accept) begin
            op_d  = aluOperation_i;
            cnt_d = 5'd0;
            neg_d = (aluOperation_i inside {ALUOP_REM, ALUOP_REMU}) ? sa : (sa ^ sb);
            if (is_div) begin
                acc_d = {32'd0, mag_a};
                opb_d = mag_b;
            end else begin
                acc_d = {32'd0, mag_b};
                opb_d = mag_a;
            end
            if (div_zero | div_ovf)
                result_d = special_res;
`ifdef MDU_FAST_MUL_EN
            else if (is_mul)
                result_d = fix_word(aluOperation_i, sa ^ sb,
                                    {32'd0, mag_a} * {32'd0, mag_b});
`endif
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q + 5'd1;
            if (is_div_op(op_q))
                acc_d = {div_ge ? div_top[31:0] - opb_q : div_top[31:0], acc_q[30:0], div_ge};
            else
                acc_d = {mul_sum, acc_q[31:1]};
        end else if (state_q == S_FIXUP && !kill_i) begin
            result_d = fix_word(op_q, neg_q, acc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, busy, kill and reset behaviour.
module tb_muldiv_unit;
    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start_i, kill_i;
    logic [4:0]  aluOperation_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .aluOperation_i(aluOperation_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .kill_i(kill_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op at the next edge and follow it to done_o (bounded wait).
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n, bc;
        aluOperation_i = op; rs1_data_i = a; rs2_data_i = b; start_i = 1'b1;
        step();
        start_i = 1'b0;
        n = 1; bc = 0;
        while (!done_o && n < 100) begin
            if (busy_o) bc++;
            step();
            n++;
        end
        if (busy_o) bc++;
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " busy cycles"}, bc, exp_lat);
        chk({tag, " result"}, result_o, exp_res);
        last_res = exp_res;
        step();
        chk({tag, " idle after done"}, {busy_o, done_o}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0;
        aluOperation_i = OP_ADD; rs1_data_i = '0; rs2_data_i = '0;
        last_res = '0;
        step(); step();
        chk("reset outputs", {busy_o, done_o, result_o}, 34'd0);
        rst_n = 1'b1;
        step();

        run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_op("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_op("DIV -7/2",   OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("REM -7/2",   OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("DIV 7/0",    OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REM 7/0",    OP_REM, 32'd7, 32'd0, 32'd7, 1);
        run_op("DIVU 5/0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("DIV ovf",    OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf",    OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("DIV 100/-7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
        run_op("MUL -1*-1",  OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MUL_LAT);
        run_op("MULH -1*-1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MUL_LAT);
        run_op("MULHU",      OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("MULHSU",     OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("MUL 1234*5678", OP_MUL, 32'd1234, 32'd5678, 32'd7006652, MUL_LAT);
        run_op("MULH -3*4",  OP_MULH, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, MUL_LAT);

        // Kill during CALC: back to IDLE, no done, result kept
        aluOperation_i = OP_DIV; rs1_data_i = 32'd100; rs2_data_i = 32'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("no done before kill", done_o, 1'b0);
            step();
        end
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        chk("kill busy/done", {busy_o, done_o}, 2'b00);
        chk("kill keeps result", result_o, last_res);
        run_op("DIVU after kill", OP_DIVU, 32'd1000, 32'd10, 32'd100, 34);

        // Kill together with start in IDLE drops the start
        aluOperation_i = OP_DIVU; start_i = 1'b1; kill_i = 1'b1;
        step();
        start_i = 1'b0; kill_i = 1'b0;
        chk("kill+start dropped", {busy_o, done_o}, 2'b00);

        // Non-RV32M code is ignored
        aluOperation_i = OP_ADD; rs1_data_i = 32'd3; rs2_data_i = 32'd4; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("ADD ignored", {busy_o, done_o}, 2'b00);
        step();
        chk("ADD still idle", {busy_o, done_o, result_o}, {2'b00, last_res});

        // Start while busy with different operands is ignored
        aluOperation_i = OP_DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step(); step();
        aluOperation_i = OP_REMU; rs1_data_i = 32'd50; rs2_data_i = 32'd3; start_i = 1'b1;
        step();
        start_i = 1'b0;
        begin
            int n;
            n = 4;
            while (!done_o && n < 100) begin
                step();
                n++;
            end
            chk("busy-start latency", n, 34);
            chk("busy-start result", result_o, 32'd14);
        end
        step();
        chk("no queued op", {busy_o, done_o}, 2'b00);

        // Reset during CALC clears everything
        aluOperation_i = OP_DIVU; rs1_data_i = 32'd99; rs2_data_i = 32'd9; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk("reset mid-op", {busy_o, done_o, result_o}, 34'd0);
        rst_n = 1'b1;
        step();
        run_op("DIVU after reset", OP_DIVU, 32'd99, 32'd9, 32'd11, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
